// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default widths,
// per-entry status flags and counter width helpers.
package fetch_pkg;

  localparam int unsigned DEF_DEPTH  = 4;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef struct packed {
    logic filled;
    logic fault;
  } entry_status_t;

  // Occupancy counter: must represent 0..DEPTH inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // In-flight/drop counters: their sum can reach 2*DEPTH.
  function automatic int unsigned ctr_w(input int unsigned depth);
    return $clog2(depth) + 2;
  endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// DEPTH-entry fetch queue storage: allocate at tail, fill by response order,
// combinational read of the head entry.
module fetch_queue_ram
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned PW     = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alloc_en,
  input  logic [PW-1:0]     alloc_idx,
  input  logic [ADDR_W-1:0] alloc_pc,
  input  logic              alloc_fault,
  input  logic              fill_en,
  input  logic [PW-1:0]     fill_idx,
  input  logic [DATA_W-1:0] fill_data,
  input  logic [PW-1:0]     head_idx,
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_data,
  output logic              head_filled,
  output logic              head_fault
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
    entry_status_t     st;
  } entry_t;

  entry_t mem [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // A fault entry is born complete: filled with zero data.
      if (alloc_en) begin
        mem[alloc_idx].pc        <= alloc_pc;
        mem[alloc_idx].data      <= '0;
        mem[alloc_idx].st.filled <= alloc_fault;
        mem[alloc_idx].st.fault  <= alloc_fault;
      end
      if (fill_en) begin
        mem[fill_idx].data      <= fill_data;
        mem[fill_idx].st.filled <= 1'b1;
      end
    end
  end

  assign head_pc     = mem[head_idx].pc;
  assign head_data   = mem[head_idx].data;
  assign head_filled = mem[head_idx].st.filled;
  assign head_fault  = mem[head_idx].st.fault;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: issues word fetches at pc, queues in-order responses
// for decode, flushes on redirect. Optional FETCH_MISALIGN_CHECK_EN fault path.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_advance,
  input  logic              flush,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned KW = ctr_w(DEPTH);

  logic [PW-1:0] head, tail, fill;
  logic [CW-1:0] count;
  logic [KW-1:0] inflight, drop;

  logic issue_ok, mem_req, mem_accept, fault_alloc, alloc;
  logic rsp_fill, pop, head_filled, head_fault;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic halted;
  logic misaligned;

  assign misaligned    = pc[1:0] != 2'b00;
  assign issue_ok      = reset && !flush && (count < CW'(DEPTH)) && !halted;
  assign mem_req       = issue_ok && !misaligned;
  assign fault_alloc   = issue_ok && misaligned;
  assign imem_req_addr = pc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)           halted <= 1'b0;
    else if (flush)       halted <= 1'b0;
    else if (fault_alloc) halted <= 1'b1;
  end
`else
  assign issue_ok      = reset && !flush && (count < CW'(DEPTH));
  assign mem_req       = issue_ok;
  assign fault_alloc   = 1'b0;
  assign imem_req_addr = {pc[ADDR_W-1:2], 2'b00};
`endif

  assign imem_req_valid = mem_req;
  assign mem_accept     = mem_req && imem_req_ready;
  assign alloc          = mem_accept || fault_alloc;
  assign pc_advance     = alloc;

  assign rsp_fill   = imem_rsp_valid && (drop == '0) && !flush;
  assign inst_valid = reset && (count != '0) && head_filled;
  assign pop        = inst_valid && inst_ready && !flush;
  assign inst_fault = inst_valid && head_fault;

  fetch_queue_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PW     (PW)
  ) u_ram (
    .clock       (clock),
    .reset       (reset),
    .alloc_en    (alloc),
    .alloc_idx   (tail),
    .alloc_pc    (pc),
    .alloc_fault (fault_alloc),
    .fill_en     (rsp_fill),
    .fill_idx    (fill),
    .fill_data   (imem_rsp_data),
    .head_idx    (head),
    .head_pc     (inst_pc),
    .head_data   (inst_data),
    .head_filled (head_filled),
    .head_fault  (head_fault)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      fill     <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      fill     <= '0;
      count    <= '0;
      // Everything still owed by memory becomes droppable, minus the
      // response consumed (and discarded) in this very cycle.
      drop     <= drop + inflight - KW'(imem_rsp_valid);
      inflight <= '0;
    end else begin
      if (alloc)    tail <= tail + PW'(1);
      if (pop)      head <= head + PW'(1);
      if (rsp_fill) fill <= fill + PW'(1);
      if (imem_rsp_valid && (drop != '0)) drop <= drop - KW'(1);
      count    <= count + CW'(alloc) - CW'(pop);
      inflight <= inflight + KW'(mem_accept) - KW'(rsp_fill);
    end
  end

endmodule
